pwm_capture: RTL and testbench

//  Decodes a PWM waveform back into a duty level: measures high-time per period between active rising edges.

---
 rtl/pwm_capture_pkg.sv | 21 ++
 rtl/pwm_capture_sync.sv | 35 +++
 rtl/pwm_capture.sv | 124 ++++++++++++
 tb/tb_pwm_capture.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for PWM capture: FSM state encoding and the
// period / stuck-timeout expressions shared with the PWM generator.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  // Nominal PWM period N for a given level width.
  function automatic int period_n(input int w);
    return 1 << w;
  endfunction

  // Stuck timeout T: two nominal periods without an active rise.
  function automatic int timeout_t(input int w);
    return 1 << (w + 1);
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_sync: 2-flop synchronizer plus delay flop for an async input.
// Ports: clk, reset (sync, active-high), raw (async in), a (active level), rise.
module pwm_sync #(
  parameter bit INVERT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic a,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic a_d;

  assign a    = s2 ^ INVERT;
  assign a_d  = s3 ^ INVERT;
  assign rise = a & ~a_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high-time per period between active rises,
// reports a saturated level with a valid pulse, flags stuck inputs.
// Ports: clk, reset (sync, active-high), pwm_in (async), level,
// level_valid, stuck, period_err (PWMCAP_PERIOD_CHECK_EN only, else 0).
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic             level_valid,
  output logic             stuck,
  output logic             period_err
);

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] N   = CW'(period_n(WIDTH));
  localparam logic [CW-1:0] SAT = '1;

  logic a;
  logic rise;

  pwm_sync #(.INVERT(INVERT)) u_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (pwm_in),
    .a     (a),
    .rise  (rise)
  );

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    per_cnt;
  logic [CW-1:0]    per_n;
  logic [CW-1:0]    hi_cnt;
  logic [CW-1:0]    hi_n;
  logic [WIDTH-1:0] level_n;
  logic             valid_n;
  logic             stuck_n;
  logic             perr_n;
  logic             timeout;
  logic             mismatch;
  logic [WIDTH-1:0] sat_level;

  // per_cnt holds completed cycles since the rise cycle, so all-ones
  // on a non-rise cycle means this is the T-th cycle with no rise.
  assign timeout   = (per_cnt == SAT);
  assign sat_level = (hi_cnt >= N) ? '1 : hi_cnt[WIDTH-1:0];

`ifdef PWMCAP_PERIOD_CHECK_EN
  assign mismatch = (per_cnt != N);
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      stuck       <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      state       <= state_n;
      per_cnt     <= per_n;
      hi_cnt      <= hi_n;
      level       <= level_n;
      level_valid <= valid_n;
      stuck       <= stuck_n;
      period_err  <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    valid_n = 1'b0;
    stuck_n = stuck;
    perr_n  = 1'b0;

    if (rise) begin
      per_n = CW'(1);
      hi_n  = CW'(1);
    end else begin
      per_n = (per_cnt == SAT) ? per_cnt : per_cnt + 1'b1;
      hi_n  = (a && hi_cnt != SAT) ? hi_cnt + 1'b1 : hi_cnt;
    end

    unique case (state)
      IDLE, MEASURE: begin
        if (rise) begin
          state_n = MEASURE;
          if (state == MEASURE) begin
            if (mismatch) begin
              perr_n = 1'b1;
            end else begin
              level_n = sat_level;
              valid_n = 1'b1;
            end
          end
        end else if (timeout) begin
          level_n = a ? '1 : '0;
          valid_n = 1'b1;
          stuck_n = 1'b1;
          state_n = STUCK;
        end
      end
      STUCK: begin
        if (rise) begin
          stuck_n = 1'b0;
          state_n = MEASURE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (WIDTH=8) with a report scoreboard.
// Also drives an INVERT=1 instance from the same input.
module tb_pwm_capture;

`ifdef PWMCAP_PERIOD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] level;
  logic       level_valid;
  logic       stuck;
  logic       period_err;
  logic [7:0] inv_level;
  logic       inv_valid;
  logic       inv_stuck;
  logic       inv_perr;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(8), .INVERT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .level       (level),
    .level_valid (level_valid),
    .stuck       (stuck),
    .period_err  (period_err)
  );

  pwm_capture #(.WIDTH(8), .INVERT(1'b1)) dut_inv (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .level       (inv_level),
    .level_valid (inv_valid),
    .stuck       (inv_stuck),
    .period_err  (inv_perr)
  );

  int checks = 0;
  int errors = 0;
  int perr_seen = 0;
  int exp_perr = 0;

  // Each entry is {stuck, level} expected with a level_valid pulse.
  logic [8:0] q[$];
  logic [8:0] exp_rep;
  logic       valid_d = 1'b0;

  bit         have_prev = 1'b0;
  logic [7:0] prev_level = '0;
  int         prev_len = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (level_valid) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_valid got level=%0d exp none", level);
        end
        if (q.size() != 0) begin
          exp_rep = q.pop_front();
          checks++;
          assert ({stuck, level} === exp_rep) else begin
            errors++;
            $error("FAIL report got stuck=%b level=%0d exp stuck=%b level=%0d",
                   stuck, level, exp_rep[8], exp_rep[7:0]);
          end
        end
        checks++;
        assert (valid_d === 1'b0) else begin
          errors++;
          $error("FAIL double_valid got %b exp 0", valid_d);
        end
      end
      if (period_err) perr_seen++;
    end
    valid_d = level_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, expv);
    end
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  // Generator model: each period with high>0 starts with a rise that
  // closes the previous window and yields its report (or period_err).
  task automatic run_pwm(input int period, input int high, input int n);
    for (int p = 0; p < n; p++) begin
      if (high > 0) begin
        if (have_prev) begin
          if (CHK && prev_len != 256) exp_perr++;
          else q.push_back({1'b0, prev_level});
        end
        have_prev  = 1'b1;
        prev_level = (high >= 256) ? 8'd255 : 8'(high);
        prev_len   = period;
      end
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        pwm_in = (c < high);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_level", 32'(level), 0);
    chk("reset_valid", 32'(level_valid), 0);
    chk("reset_stuck", 32'(stuck), 0);
    chk("reset_perr", 32'(period_err), 0);
    reset = 1'b0;

    // 1: steady 64, first rise unreported
    run_pwm(256, 64, 5);
    // 2: 255, 1, then 64 -> 200 mid-run
    run_pwm(256, 255, 3);
    run_pwm(256, 1, 3);
    run_pwm(256, 64, 2);
    run_pwm(256, 200, 3);
    chk("lvl_200", 32'(level), 200);

    // 3: stuck low, then recovery at 10
    q.push_back({1'b1, 8'd0});
    have_prev = 1'b0;
    idle(600, 1'b0);
    chk("stuck_lo", 32'(stuck), 1);
    chk("stuck_lo_lvl", 32'(level), 0);
    run_pwm(256, 10, 1);
    chk("unstuck", 32'(stuck), 0);
    run_pwm(256, 10, 2);
    chk("lvl_10", 32'(level), 10);

    // 4: forced high; inverted instance sees stuck low
    q.push_back({1'b0, prev_level});
    q.push_back({1'b1, 8'd255});
    have_prev = 1'b0;
    idle(600, 1'b1);
    chk("stuck_hi", 32'(stuck), 1);
    chk("stuck_hi_lvl", 32'(level), 255);
    chk("inv_stuck", 32'(inv_stuck), 1);
    chk("inv_lvl", 32'(inv_level), 0);
    idle(5, 1'b0);

    // 5: direct drive period 200, high 50
    run_pwm(200, 50, 4);
    chk("p200_lvl", 32'(level), CHK ? 255 : 50);
    chk("p200_stuck", 32'(stuck), 0);
    q.push_back({1'b1, 8'd0});
    have_prev = 1'b0;
    idle(600, 1'b0);
    chk("stuck_lo2", 32'(stuck), 1);

    // 6: reset mid-window
    run_pwm(256, 64, 1);
    q.push_back({1'b0, 8'd64});
    have_prev = 1'b0;
    idle(30, 1'b1);
    chk("q_drained", q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(level_valid), 0);
    chk("rst_stuck", 32'(stuck), 0);
    chk("rst_perr", 32'(period_err), 0);
    reset = 1'b0;
    idle(100, 1'b0);
    run_pwm(256, 64, 3);
    idle(20, 1'b0);

    chk("q_empty", q.size(), 0);
    chk("perr_count", perr_seen, exp_perr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
